regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//   Shares the single write port of the 16-bit register bank (reg16 instances,
//   one Write strobe per port) between three requesters: 0=ALU writeback,
//   1=memory load, 2=link/interrupt save. Round-robin arbitration, one write per cycle,
//   req/grant handshake. Sits between the control unit and the register file.
// PARAMETERS
//   DATA_W    16   width of write data and of the target registers
//   ADDR_W    4    register address width (16 registers)
//   ZERO_REG  1    1: register 0 is hardwired; writes to address 0 are granted but suppressed
// PORTS
//   CLK      in   1           rising-edge clock
//   Reset    in   1           synchronous, active-high reset
//   Req      in   3           Req[i]=1: requester i wants a write; held until Gnt[i]
//   ReqAddr  in   3*ADDR_W    requester i address in bits [i*ADDR_W +: ADDR_W]
//   ReqData  in   3*DATA_W    requester i data in bits [i*DATA_W +: DATA_W]
//   Gnt      out  3           one-hot, one-cycle grant pulse
//   Write    out  1           write strobe to register bank (drives reg16 Write)
//   WAddr    out  ADDR_W      register address for the current write
//   WData    out  DATA_W      data for the current write (drives reg16 I)
//   Conflict out  1           1 when >1 eligible requester was seen at the last edge
// BEHAVIOUR
//   - All outputs registered. Reset (sampled at posedge CLK): Gnt=0, Write=0,
//     WAddr=0, WData=0, Conflict=0, RR pointer=0 (requester 0 highest priority).
//     Reset wins over any Req at the same edge; in-flight grant is dropped.
//   - Eligible[i] = Req[i] & ~Gnt[i] (requester granted this cycle is masked,
//     since it cannot yet have dropped Req).
//   - At each posedge with eligible!=0: winner w = first eligible searching
//     ptr, ptr+1, ptr+2 (mod 3). Next cycle: Gnt=one-hot(w), WAddr/WData =
//     slice w, Write=1 unless ZERO_REG && slice-w addr==0 (then Write=0, Gnt still 1).
//     ptr <= (w+1) mod 3.
//   - No eligible request: Gnt=0, Write=0, WAddr/WData hold last values, ptr holds.
//   - Latency: Req rising before edge N -> Gnt/Write high in cycle after edge N
//     (1 cycle) when uncontested; reg16 captures WData on the following edge N+1.
//   - Requester i must keep ReqAddr/ReqData stable while Req[i]=1 and Gnt[i]=0;
//     may drop or re-raise Req in the cycle Gnt[i]=1. Re-raised Req is served
//     no earlier than 2 cycles after the previous grant.
//   - Different requesters can be granted back-to-back (Write high every cycle).
//   - Conflict <= (popcount(eligible) >= 2) each edge; 0 after reset.
//   - Worst-case wait for a held request: 2 grant slots (no starvation).
//   - Req deasserted before being granted: request withdrawn, no write, ptr unaffected.
// TESTING
//   1. Reset=1 with Req=3'b111 for 2 cycles -> Gnt=0, Write=0, WAddr=0, WData=0.
//   2. Req=3'b001, addr 5, data 16'hFFFF -> next cycle Gnt=001, Write=1, WAddr=5,
//      WData=FFFF; after grant Req dropped, reg 5 reads FFFF; next cycle Write=0.
//   3. Req=3'b111 held continuously from ptr=0 -> grants 001,010,100,001... each
//      1 cycle, Write=1 every cycle, Conflict=1.
//   4. Req[1] only, held high 6 cycles -> Gnt=010 on alternate cycles only (masking).
//   5. ZERO_REG=1, Req[2] addr 0 data 16'h1111 -> Gnt=100, Write=0, reg 0 unchanged.
//   6. Reset asserted in the cycle Gnt=010/Write=1 -> next cycle all outputs 0,
//      ptr=0; with Req=3'b110 then, requester 1 is granted first.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//   Shares the single write port of the register bank between three
//   requesters: 0 = ALU writeback, 1 = memory load, 2 = link/interrupt save.
//   Round-robin arbitration grants at most one write per cycle. Every output
//   is registered.
//
// Ports
//   CLK       in   1          rising-edge clock
//   Reset     in   1          synchronous, active-high reset
//   Req       in   3          Req[i]=1: requester i wants a write
//   ReqAddr   in   3*ADDR_W   requester i address in [i*ADDR_W +: ADDR_W]
//   ReqData   in   3*DATA_W   requester i data in [i*DATA_W +: DATA_W]
//   Gnt       out  3          one-hot, one-cycle grant pulse
//   Write     out  1          write strobe to the register bank
//   WAddr     out  ADDR_W     register address for the current write
//   WData     out  DATA_W     data for the current write
//   Conflict  out  1          >1 eligible requester was seen at the last edge
//
// Handshake: a requester raises Req[i] and holds Req/ReqAddr/ReqData stable
//   until it sees Gnt[i]=1. In the Gnt[i] cycle it may drop Req[i] or raise
//   it again with a new address/data; because Gnt[i] masks Req[i] for that
//   edge, a re-raised request is served no earlier than two cycles after the
//   previous grant. Dropping Req[i] before a grant withdraws the request.
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic [2:0]          Req,
  input  logic [3*ADDR_W-1:0] ReqAddr,
  input  logic [3*DATA_W-1:0] ReqData,
  output logic [2:0]          Gnt,
  output logic                Write,
  output logic [ADDR_W-1:0]   WAddr,
  output logic [DATA_W-1:0]   WData,
  output logic                Conflict
);

  logic [2:0]        r_gnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_conflict;
  logic [1:0]        r_ptr;      // requester with highest priority next edge

  logic [2:0]        w_elig;
  logic [2:0]        w_rot;
  logic [1:0]        w_off;
  logic [2:0]        w_sum;
  logic [1:0]        w_win;
  logic [1:0]        w_next_ptr;
  logic [2:0]        w_gnt_oh;
  logic              w_any;
  logic              w_conflict;
  logic              w_zero_hit;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  always_comb begin
    // A requester granted this cycle is still holding Req; mask it so the
    // same request is not written twice.
    w_elig = Req & ~r_gnt;

    // Rotate so that bit 0 is the requester at the pointer; the first set
    // bit of w_rot is then the round-robin winner's offset from r_ptr.
    case (r_ptr)
      2'd1:    w_rot = {w_elig[0], w_elig[2], w_elig[1]};
      2'd2:    w_rot = {w_elig[1], w_elig[0], w_elig[2]};
      default: w_rot = w_elig;
    endcase

    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else               w_off = 2'd2;

    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= 3'd3) w_sum = w_sum - 3'd3;
    w_win = w_sum[1:0];

    w_next_ptr = (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;

    case (w_win)
      2'd1: begin
        w_gnt_oh = 3'b010;
        w_addr   = ReqAddr[1*ADDR_W +: ADDR_W];
        w_data   = ReqData[1*DATA_W +: DATA_W];
      end
      2'd2: begin
        w_gnt_oh = 3'b100;
        w_addr   = ReqAddr[2*ADDR_W +: ADDR_W];
        w_data   = ReqData[2*DATA_W +: DATA_W];
      end
      default: begin
        w_gnt_oh = 3'b001;
        w_addr   = ReqAddr[0 +: ADDR_W];
        w_data   = ReqData[0 +: DATA_W];
      end
    endcase

    w_any      = |w_elig;
    // At least two of three bits set.
    w_conflict = (w_elig[0] & w_elig[1]) | (w_elig[0] & w_elig[2]) |
                 (w_elig[1] & w_elig[2]);
    // Register 0 is hardwired: the grant still happens, the strobe does not.
    w_zero_hit = (ZERO_REG != 0) && (w_addr == '0);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_gnt      <= 3'b000;
      r_write    <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_conflict <= 1'b0;
      r_ptr      <= 2'd0;
    end else begin
      r_conflict <= w_conflict;
      if (w_any) begin
        r_gnt   <= w_gnt_oh;
        r_write <= ~w_zero_hit;
        r_waddr <= w_addr;
        r_wdata <= w_data;
        r_ptr   <= w_next_ptr;
      end else begin
        // Idle: address/data hold their last values, pointer unchanged.
        r_gnt   <= 3'b000;
        r_write <= 1'b0;
      end
    end
  end

  assign Gnt      = r_gnt;
  assign Write    = r_write;
  assign WAddr    = r_waddr;
  assign WData    = r_wdata;
  assign Conflict = r_conflict;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int DW = 16;
  localparam int AW = 4;

  logic            CLK;
  logic            Reset;
  logic [2:0]      Req;
  logic [3*AW-1:0] ReqAddr;
  logic [3*DW-1:0] ReqData;
  logic [2:0]      Gnt;
  logic            Write;
  logic [AW-1:0]   WAddr;
  logic [DW-1:0]   WData;
  logic            Conflict;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .CLK(CLK), .Reset(Reset), .Req(Req), .ReqAddr(ReqAddr), .ReqData(ReqData),
    .Gnt(Gnt), .Write(Write), .WAddr(WAddr), .WData(WData), .Conflict(Conflict)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register bank fed by the DUT's write port (acts like the reg16 array).
  logic [DW-1:0] d_bank [16] = '{default: 16'hA5A5};
  always @(posedge CLK) begin
    if (Write) d_bank[WAddr] <= WData;
  end

  // ---------------- reference model ----------------
  int            m_ptr;
  logic [2:0]    m_gnt;
  logic          m_write;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic          m_conf;
  logic [DW-1:0] m_bank [16] = '{default: 16'hA5A5};

  // Applies the current inputs at the next rising edge, both to the model
  // and to the DUT, then returns 1 time unit after the edge.
  task automatic tick();
    int cnt;
    int w;
    logic [2:0] elig;
    if (m_write) m_bank[m_waddr] = m_wdata;
    if (Reset) begin
      m_gnt = 3'b000; m_write = 1'b0; m_waddr = '0; m_wdata = '0;
      m_conf = 1'b0; m_ptr = 0;
    end else begin
      elig = Req & ~m_gnt;
      cnt  = 0;
      for (int i = 0; i < 3; i++) if (elig[i]) cnt++;
      m_conf = (cnt >= 2);
      if (cnt == 0) begin
        m_gnt = 3'b000; m_write = 1'b0;
      end else begin
        w = -1;
        for (int k = 0; k < 3; k++) begin
          if (w < 0 && elig[(m_ptr + k) % 3]) w = (m_ptr + k) % 3;
        end
        m_gnt   = 3'b000;
        m_gnt[w] = 1'b1;
        m_waddr = ReqAddr[w*AW +: AW];
        m_wdata = ReqData[w*DW +: DW];
        m_write = (m_waddr != 0);
        m_ptr   = (w + 1) % 3;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [24:0] dut_vec();
    return {Gnt, Write, WAddr, WData, Conflict};
  endfunction

  function automatic logic [24:0] mdl_vec();
    return {m_gnt, m_write, m_waddr, m_wdata, m_conf};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b1;
    Req   = 3'b111;
    ReqAddr = {4'd3, 4'd2, 4'd1};
    ReqData = {16'h3333, 16'h2222, 16'h1111};
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if ({Gnt, Write, WAddr, WData, Conflict} !== 25'd0) begin
        n_bad++;
        $display("FAIL reset_outputs cyc=%0d: got %h expected 0", c, dut_vec());
      end
    end
  endtask

  task automatic test_single();
    Reset = 1'b0;
    Req   = 3'b001;
    ReqAddr[0 +: AW] = 4'd5;
    ReqData[0 +: DW] = 16'hFFFF;
    tick();
    n_cmp++;
    if ({Gnt, Write, WAddr, WData} !== {3'b001, 1'b1, 4'd5, 16'hFFFF}) begin
      n_bad++;
      $display("FAIL single_grant: got gnt=%b wr=%b a=%h d=%h expected 001 1 5 ffff",
               Gnt, Write, WAddr, WData);
    end
    Req = 3'b000;
    tick();
    n_cmp++;
    if (Gnt !== 3'b000 || Write !== 1'b0) begin
      n_bad++;
      $display("FAIL single_release: got gnt=%b wr=%b expected 000 0", Gnt, Write);
    end
    n_cmp++;
    if (d_bank[5] !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL single_reg5: got %h expected ffff", d_bank[5]);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_seq [3] = '{3'b001, 3'b010, 3'b100};
    Reset = 1'b1; Req = 3'b000;
    tick();
    Reset = 1'b0;
    Req = 3'b111;
    ReqAddr = {4'd12, 4'd11, 4'd10};
    ReqData = {16'hC0C0, 16'hB0B0, 16'hA0A0};
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if (Gnt !== exp_seq[c % 3] || Write !== 1'b1 || Conflict !== 1'b1) begin
        n_bad++;
        $display("FAIL rr_all_held cyc=%0d: got gnt=%b wr=%b cf=%b expected %b 1 1",
                 c, Gnt, Write, Conflict, exp_seq[c % 3]);
      end
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL rr_model cyc=%0d: got %h expected %h", c, dut_vec(), mdl_vec());
      end
    end
    Req = 3'b000;
    tick();
  endtask

  task automatic test_masking();
    Reset = 1'b1; Req = 3'b000;
    tick();
    Reset = 1'b0;
    Req = 3'b010;
    ReqAddr[1*AW +: AW] = 4'd7;
    ReqData[1*DW +: DW] = DW'($urandom);
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if (Gnt !== ((c % 2 == 0) ? 3'b010 : 3'b000) || Conflict !== 1'b0) begin
        n_bad++;
        $display("FAIL masking cyc=%0d: got gnt=%b cf=%b expected %b 0",
                 c, Gnt, Conflict, (c % 2 == 0) ? 3'b010 : 3'b000);
      end
    end
    Req = 3'b000;
    tick();
  endtask

  task automatic test_zero_reg();
    Req = 3'b100;
    ReqAddr[2*AW +: AW] = 4'd0;
    ReqData[2*DW +: DW] = 16'h1111;
    tick();
    n_cmp++;
    if (Gnt !== 3'b100 || Write !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_reg_grant: got gnt=%b wr=%b expected 100 0", Gnt, Write);
    end
    Req = 3'b000;
    tick();
    n_cmp++;
    if (d_bank[0] !== 16'hA5A5) begin
      n_bad++;
      $display("FAIL zero_reg_unchanged: got %h expected a5a5", d_bank[0]);
    end
  endtask

  task automatic test_reset_midgrant();
    Reset = 1'b1; Req = 3'b000;
    tick();
    Reset = 1'b0;
    Req = 3'b010;
    ReqAddr = {4'd4, 4'd9, 4'd1};
    ReqData = {16'h4444, 16'h9999, 16'h1010};
    tick();
    n_cmp++;
    if (Gnt !== 3'b010 || Write !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_grant: got gnt=%b wr=%b expected 010 1", Gnt, Write);
    end
    Reset = 1'b1;
    Req = 3'b110;
    tick();
    n_cmp++;
    if (dut_vec() !== 25'd0) begin
      n_bad++;
      $display("FAIL midgrant_reset: got %h expected 0", dut_vec());
    end
    Reset = 1'b0;
    tick();
    n_cmp++;
    if (Gnt !== 3'b010 || WAddr !== 4'd9 || WData !== 16'h9999) begin
      n_bad++;
      $display("FAIL post_reset_first: got gnt=%b a=%h d=%h expected 010 9 9999",
               Gnt, WAddr, WData);
    end
    tick();
    n_cmp++;
    if (Gnt !== 3'b100 || WAddr !== 4'd4) begin
      n_bad++;
      $display("FAIL post_reset_second: got gnt=%b a=%h expected 100 4", Gnt, WAddr);
    end
    Req = 3'b000;
    tick();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 400; c++) begin
      Reset = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < 3; i++) begin
        if (m_gnt[i] || !Req[i]) begin
          // Free to (re)issue: new request with fresh address/data, or idle.
          if ($urandom_range(0, 2) != 0) begin
            Req[i] = 1'b1;
            ReqAddr[i*AW +: AW] = AW'($urandom_range(0, 15));
            ReqData[i*DW +: DW] = DW'($urandom);
          end else begin
            Req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 9) == 0) begin
          Req[i] = 1'b0;  // withdraw a pending request
        end
      end
      tick();
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        errs++;
        if (errs <= 10)
          $display("FAIL random cyc=%0d: got %h expected %h", c, dut_vec(), mdl_vec());
      end
    end
    Reset = 1'b0;
    Req = 3'b000;
    tick();
    tick();
    for (int r = 0; r < 16; r++) begin
      n_cmp++;
      if (d_bank[r] !== m_bank[r]) begin
        n_bad++;
        $display("FAIL bank_reg%0d: got %h expected %h", r, d_bank[r], m_bank[r]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    Reset = 1'b1;
    Req = 3'b000;
    ReqAddr = '0;
    ReqData = '0;
    m_ptr = 0; m_gnt = 3'b000; m_write = 1'b0; m_waddr = '0; m_wdata = '0; m_conf = 1'b0;
    @(negedge CLK);
    test_reset();
    test_single();
    test_back_to_back();
    test_masking();
    test_zero_reg();
    test_reset_midgrant();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
